// File: rtl/pipelined_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipelined_adder : WIDTH-bit a+b+cin split into STAGES carry-chain        |
// | segments with valid/ready flow control and per-stage bubble collapsing.  |
// | Optional macro PIPELINED_ADDER_OVF_EN adds a registered signed ovf port. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES:0] stage_ready;

  assign stage_ready[STAGES] = out_ready;
  assign in_ready            = stage_ready[0];

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_a;
    logic [WIDTH-1:0] up_b;
    logic [WIDTH-1:0] up_sum;
    logic             up_carry;
    logic             load;
    logic [CHUNK:0]   add_d;
    logic [WIDTH-1:0] sum_d;
    logic             valid_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_a     = a;
      assign up_b     = b;
      assign up_sum   = '0;
      assign up_carry = cin;
    end else begin : g_body
      assign up_valid = g_stage[k-1].valid_q;
      assign up_a     = g_stage[k-1].g_fwd.opa_q;
      assign up_b     = g_stage[k-1].g_fwd.opb_q;
      assign up_sum   = g_stage[k-1].sum_q;
      assign up_carry = g_stage[k-1].carry_q;
    end

    assign stage_ready[k] = !valid_q || stage_ready[k+1];
    assign load           = stage_ready[k] && up_valid;

    // Operands travel right-shifted, so every stage consumes the low chunk;
    // finished sum chunks enter from the top and end up in place at the tail.
    assign add_d = {1'b0, up_a[CHUNK-1:0]} + {1'b0, up_b[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, up_carry};
    assign sum_d = WIDTH'({add_d[CHUNK-1:0], up_sum} >> CHUNK);

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (stage_ready[k]) begin
        valid_q <= up_valid;
        if (up_valid) begin
          carry_q <= add_d[CHUNK];
          sum_q   <= sum_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:0] opa_q;
      logic [WIDTH-1:0] opb_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (load) begin
          opa_q <= up_a >> CHUNK;
          opb_q <= up_b >> CHUNK;
        end
      end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    if (k == STAGES - 1) begin : g_tail
      logic ovf_q;

      // The last stage sees the operand MSBs, so signed overflow resolves here.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (load) begin
          ovf_q <= (up_a[CHUNK-1] == up_b[CHUNK-1]) && (add_d[CHUNK-1] != up_a[CHUNK-1]);
        end
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].carry_q;
`ifdef PIPELINED_ADDER_OVF_EN
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// Scoreboard bench for pipelined_adder: 8/2 directed + random, 1/1 exhaustive,
// 32/8 random stream under random back-pressure.
module tb_pipelined_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 8/2 ----------------
  logic       iv8, ir8, ov8, or8, cin8, co8, ovf8;
  logic [7:0] a8, b8, s8;
  // ---------------- DUT 1/1 ----------------
  logic       iv1, ir1, ov1, or1, cin1, co1, ovf1;
  logic [0:0] a1, b1, s1;
  // ---------------- DUT 32/8 ---------------
  logic        iv32, ir32, ov32, or32, cin32, co32, ovf32;
  logic [31:0] a32, b32, s32;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8)
`ifdef PIPELINED_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );
  pipelined_adder #(.WIDTH(1), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1)
`ifdef PIPELINED_ADDER_OVF_EN
    , .ovf(ovf1)
`endif
  );
  pipelined_adder #(.WIDTH(32), .STAGES(8)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32),
    .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32)
`ifdef PIPELINED_ADDER_OVF_EN
    , .ovf(ovf32)
`endif
  );

`ifndef PIPELINED_ADDER_OVF_EN
  assign ovf8  = 1'b0;
  assign ovf1  = 1'b0;
  assign ovf32 = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packed reference: bits [w-1:0] sum, bit w cout, bit w+1 ovf.
  function automatic logic [63:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic c);
    logic [32:0] t;
    logic [63:0] r;
    logic        o;
    t = {1'b0, a} + {1'b0, b} + {32'd0, c};
    o = (a[w-1] == b[w-1]) && (t[w-1] != a[w-1]);
`ifndef PIPELINED_ADDER_OVF_EN
    o = 1'b0;
`endif
    r = 64'(t) & ((64'd1 << (w + 1)) - 64'd1);
    r = r | (64'(o) << (w + 1));
    return r;
  endfunction

  logic [63:0] q8[$];
  logic [63:0] q1[$];
  logic [63:0] q32[$];
  int pops8 = 0, pops1 = 0, pops32 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q8.delete(); q1.delete(); q32.delete();
    end else begin
      if (ov8 && or8) begin
        if (q8.size() == 0) check_eq("dut8 stale result", 64'(ov8), 0);
        else begin check_eq("dut8 result", {54'd0, ovf8, co8, s8}, q8.pop_front()); pops8++; end
      end
      if (iv8 && ir8) q8.push_back(model(8, 32'(a8), 32'(b8), cin8));
      if (ov1 && or1) begin
        if (q1.size() == 0) check_eq("dut1 stale result", 64'(ov1), 0);
        else begin check_eq("dut1 result", {61'd0, ovf1, co1, s1}, q1.pop_front()); pops1++; end
      end
      if (iv1 && ir1) q1.push_back(model(1, 32'(a1), 32'(b1), cin1));
      if (ov32 && or32) begin
        if (q32.size() == 0) check_eq("dut32 stale result", 64'(ov32), 0);
        else begin check_eq("dut32 result", {30'd0, ovf32, co32, s32}, q32.pop_front()); pops32++; end
      end
      if (iv32 && ir32) q32.push_back(model(32, a32, b32, cin32));
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic ok;
    ok  = 1'b0;
    iv8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = ir8;
      @(posedge clk);
      #1;
    end
    if (!ok) check_eq("send8 timeout in_ready", 64'(ir8), 1);
    iv8 = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && (q8.size() + q1.size() + q32.size()) != 0; i++) @(posedge clk);
    #1;
    check_eq(tag, 64'(q8.size() + q1.size() + q32.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n, p0;
    logic [7:0] head;
    rst_n = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; or8 = 1;
    iv1 = 0; a1 = 0; b1 = 0; cin1 = 0; or1 = 1;
    iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; or32 = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check_eq("reset out_valid", 64'(ov8), 0);
    check_eq("reset sum", 64'(s8), 0);
    check_eq("reset cout", 64'(co8), 0);
    check_eq("reset in_ready", 64'(ir8), 1);
    check_eq("reset ovf", 64'(ovf8), 0);

    // Latency with no back-pressure.
    t0 = cyc;
    send8(8'h3C, 8'h41, 1'b0);
    check_eq("lat8 in_ready", 64'(ir8), 1);
    for (n = 0; n < 20 && !ov8; n++) begin @(posedge clk); #1; end
    check_eq("lat8 cycles", 64'(cyc - t0), 2);
    check_eq("lat8 sum", 64'(s8), 64'h7D);
    drain("drain basic");

    // Wrap-around and signed-overflow corners.
    send8(8'hFF, 8'h00, 1'b1);
    send8(8'h7F, 8'h01, 1'b0);
    send8(8'h80, 8'h80, 1'b0);
    drain("drain corners");

    // Back-to-back stream, one accept per cycle.
    p0 = pops8;
    t0 = cyc;
    for (int i = 0; i < 10; i++) send8(8'($urandom), 8'($urandom), 1'($urandom));
    check_eq("stream8 accept rate", 64'(cyc - t0), 10);
    drain("drain stream");
    check_eq("stream8 count", 64'(pops8 - p0), 10);

    // Back-pressure: two fill the pipe, third waits.
    p0 = pops8;
    or8 = 1'b0;
    send8(8'h11, 8'h22, 1'b0);
    send8(8'h33, 8'h44, 1'b1);
    iv8 = 1'b1; a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b1;
    head = s8;
    check_eq("bp full in_ready", 64'(ir8), 0);
    check_eq("bp head sum", 64'(s8), 64'h33);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("bp head stable", 64'(s8), 64'(head));
      check_eq("bp in_ready held", 64'(ir8), 0);
    end
    check_eq("bp queue depth", 64'(q8.size()), 2);
    or8 = 1'b1;
    t0 = cyc;
    send8(8'h55, 8'hAA, 1'b1);
    check_eq("bp shift accept", 64'(cyc - t0), 1);
    drain("drain bp");
    check_eq("bp count", 64'(pops8 - p0), 3);

    // Reset while two transactions are in flight.
    send8(8'h01, 8'h02, 1'b0);
    send8(8'h03, 8'h04, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("midrst out_valid", 64'(ov8), 0);
    check_eq("midrst sum", 64'(s8), 0);
    check_eq("midrst cout", 64'(co8), 0);
    check_eq("midrst in_ready", 64'(ir8), 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("midrst no stale", 64'(ov8), 0);
    end

    // 1-bit single stage: latency then exhaustive truth table.
    t0 = cyc;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk); #1;
    iv1 = 1'b0;
    for (n = 0; n < 20 && !ov1; n++) begin @(posedge clk); #1; end
    check_eq("lat1 cycles", 64'(cyc - t0), 1);
    drain("drain lat1");
    p0 = pops1;
    for (int i = 0; i < 8; i++) begin
      iv1 = 1'b1; a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i);
      @(posedge clk); #1;
    end
    iv1 = 1'b0;
    drain("drain dut1");
    check_eq("dut1 truth count", 64'(pops1 - p0), 8);

    // 32-bit, 8 stages: latency then random stream with random out_ready.
    t0 = cyc;
    iv32 = 1'b1; a32 = 32'hFFFF_FFFF; b32 = 32'h0; cin32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0;
    for (n = 0; n < 40 && !ov32; n++) begin @(posedge clk); #1; end
    check_eq("lat32 cycles", 64'(cyc - t0), 8);
    drain("drain lat32");
    p0 = pops32;
    for (int i = 0; i < 300; i++) begin
      or32  = ($urandom_range(0, 3) != 0);
      iv32  = 1'($urandom);
      a32   = $urandom; b32 = $urandom; cin32 = 1'($urandom);
      @(posedge clk); #1;
    end
    iv32 = 1'b0; or32 = 1'b1;
    drain("drain dut32");
    check_eq("dut32 made progress", 64'(pops32 - p0 > 50), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
